// File: rtl/multicycle_sequencer_if.sv
// Handshake and decode bundle between the multicycle sequencer and its datapath/memories.
// dbg_step exists only when SEQ_SINGLE_STEP_EN is defined.
interface multicycle_sequencer_if #(
  parameter int RETIRE_W = 32
);
  logic                start;
  logic                MemRead;
  logic                MemWrite;
  logic                RegWrite;
  logic                Branch;
  logic                stop;
  logic                imem_ready;
  logic                dmem_ready;
`ifdef SEQ_SINGLE_STEP_EN
  logic                dbg_step;
`endif
  logic                imem_req;
  logic                ir_we;
  logic                dmem_req;
  logic                dmem_we;
  logic                reg_we;
  logic                pc_we;
  logic                retire;
  logic [RETIRE_W-1:0] retire_cnt;
  logic                halted;
  logic                fault;
  logic [2:0]          state;

  modport master (
    output start, MemRead, MemWrite, RegWrite, Branch, stop, imem_ready, dmem_ready,
`ifdef SEQ_SINGLE_STEP_EN
    output dbg_step,
`endif
    input  imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, retire,
    input  retire_cnt, halted, fault, state
  );

  modport slave (
    input  start, MemRead, MemWrite, RegWrite, Branch, stop, imem_ready, dmem_ready,
`ifdef SEQ_SINGLE_STEP_EN
    input  dbg_step,
`endif
    output imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, retire,
    output retire_cnt, halted, fault, state
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with halt, memory timeout and retire count.
// Optional macro SEQ_SINGLE_STEP_EN: each retire returns to IDLE and dbg_step runs one instruction.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_sequencer_if.slave          bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    FAULT  = 3'd7
  } state_e;

  localparam logic [7:0] LastWait = 8'(MEM_TIMEOUT - 1);

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_e RetireTarget = IDLE;
  logic launch;
  assign launch = bus.start | bus.dbg_step;
`else
  localparam state_e RetireTarget = FETCH;
  logic launch;
  assign launch = bus.start;
`endif

  state_e              state_q, state_d;
  logic [7:0]          wait_q, wait_d;
  logic [RETIRE_W-1:0] retire_cnt_q;
  logic                timed_out;

  logic imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, retire;

  assign timed_out = (wait_q == LastWait);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire) begin
        retire_cnt_q <= retire_cnt_q + 1'b1;
      end
    end
  end

  // Every transition into FETCH or MEM clears the wait counter so each request gets a full budget.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    pc_we    = 1'b0;
    retire   = 1'b0;
    unique case (state_q)
      IDLE: begin
        wait_d = '0;
        if (launch) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (timed_out) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DECODE: begin
        if (bus.stop) begin
          retire  = 1'b1;
          state_d = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (bus.MemRead || bus.MemWrite) begin
          wait_d  = '0;
          state_d = MEM;
        end else if (bus.RegWrite) begin
          state_d = WB;
        end else begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          wait_d  = '0;
          state_d = RetireTarget;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = bus.MemWrite;
        if (bus.dmem_ready) begin
          if (bus.MemRead) begin
            state_d = WB;
          end else begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            wait_d  = '0;
            state_d = RetireTarget;
          end
        end else if (timed_out) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        wait_d  = '0;
        state_d = RetireTarget;
      end
      HALT:  state_d = HALT;
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req   = imem_req;
  assign bus.ir_we      = ir_we;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.reg_we     = reg_we;
  assign bus.pc_we      = pc_we;
  assign bus.retire     = retire;
  assign bus.retire_cnt = retire_cnt_q;
  assign bus.halted     = (state_q == HALT);
  assign bus.fault      = (state_q == FAULT);
  assign bus.state      = state_q;

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that steps the CPU datapath through FETCH, DECODE, EXEC, MEM and WB.
- Consumes the combinational decode outputs of the instruction decoder (MemRead, MemWrite, RegWrite, Branch, stop).
- Drives register/PC/IR write enables and request/ready handshakes to instruction and data memory.
- Detects halt (ECALL), detects memory-timeout faults, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request waits for ready before FAULT; legal range 2..255.
- RETIRE_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level; leaves IDLE
- MemRead  in  1  decode: load
- MemWrite  in  1  decode: store
- RegWrite  in  1  decode: writes rd
- Branch  in  1  decode: branch/jump (informational; PC update path unchanged)
- stop  in  1  decode: ECALL
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_we  out  1  latch instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write qualifier
- reg_we  out  1  register file write enable
- pc_we  out  1  PC update enable
- retire  out  1  one-cycle pulse per completed instruction
- retire_cnt  out  RETIRE_W  retired-instruction count
- halted  out  1  sticky, in HALT
- fault  out  1  sticky, in FAULT
- state  out  3  current state, for debug

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- rst: state=IDLE, wait_cnt=0, retire_cnt=0. All outputs are 0 in the cycle after reset.
- A reset mid-instruction aborts the instruction: no pc_we and no retire.
- All enables are combinational from state and the ready inputs. Decode inputs are stable from DECODE through WB.
- IDLE: all enables 0. start=1 -> FETCH.
- FETCH: imem_req=1.
  - imem_ready=1: ir_we=1 that cycle -> DECODE.
  - Otherwise wait_cnt increments.
- DECODE: one cycle.
  - stop=1: retire=1 -> HALT.
  - Otherwise -> EXEC.
- EXEC: one cycle.
  - MemRead|MemWrite -> MEM.
  - Else RegWrite -> WB.
  - Else pc_we=1, retire=1 -> FETCH. This covers branches.
- MEM: dmem_req=1, dmem_we=MemWrite.
  - dmem_ready=1 and MemRead -> WB.
  - dmem_ready=1 and store: pc_we=1, retire=1 -> FETCH.
  - Otherwise wait_cnt increments.
  - MemRead and MemWrite both 1: treat as load; dmem_we still follows MemWrite.
- WB: reg_we=1, pc_we=1, retire=1 -> FETCH.
- Timeout:
  - wait_cnt clears on every entry to FETCH or MEM.
  - If ready is still low in the cycle where wait_cnt==MEM_TIMEOUT-1, next state is FAULT.
  - Ready asserted in that same cycle wins: normal transition, no fault.
- Cycles per instruction at zero wait states:
  - ALU op: FETCH, DECODE, EXEC, WB = 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- HALT: halted=1, all enables 0, sticky until rst; start ignored.
- FAULT: fault=1, all enables 0, sticky until rst.
- retire_cnt increments on every retire pulse and wraps from all-ones to 0 silently.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input dbg_step (1 bit).
  - Every retire that would go to FETCH goes to IDLE instead.
  - IDLE -> FETCH on start=1 or dbg_step=1, so a dbg_step pulse executes exactly one instruction.
  - HALT and FAULT behaviour unchanged.
- Undefined:
  - No dbg_step port.
  - Retire -> FETCH directly.

Test Plan:
- Reset then start=1, R-type (RegWrite=1), zero-wait ready -> states 1,2,3,5,1; reg_we and pc_we high only in WB; retire_cnt=1 after 4 cycles.
- Load (MemRead=1, RegWrite=1), dmem_ready delayed 3 cycles -> MEM held 4 cycles with dmem_req=1, dmem_we=0; then WB; 8 cycles total.
- Store (MemWrite=1), then branch (Branch=1, RegWrite=0) -> store: dmem_we=1 in MEM, pc_we in MEM ready cycle; branch: pc_we in EXEC, 3 cycles; retire_cnt=2.
- imem_ready held 0 with MEM_TIMEOUT=16 -> FAULT entered 16 cycles after FETCH entry, fault=1 sticky. Separate run with ready in cycle 16 -> no fault.
- stop=1 at DECODE -> retire pulse, HALT, halted=1; start toggled -> no change; rst=1 -> IDLE, retire_cnt=0.
- SEQ_SINGLE_STEP_EN defined: two dbg_step pulses 10 cycles apart, R-type stream -> exactly 2 retires, IDLE between; rst asserted during MEM -> IDLE, no retire.
